// File: rtl/gen_scope_video_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gen_scope_video_if
//  Purpose  : Sample bus into the scope renderer: a one-cycle valid strobe,
//             packed per-channel PCM samples (ch0 in LSBs) and the ch0
//             trigger threshold.
//  Revision : 1.0  initial release
// ============================================================================
interface gen_scope_video_if #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16
);
  logic                         sample_valid;
  logic [CHANNELS*SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0]          trig_level;

  // Sample source
  modport master (output sample_valid, sample, trig_level);
  // Scope renderer
  modport slave  (input  sample_valid, sample, trig_level);
endinterface
`default_nettype wire

// File: rtl/gen_scope_video.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gen_scope_video
//  Purpose  : Oscilloscope overlay for the HDMI pixel stream. Captures a
//             triggered window of samples into a double-buffered RAM, swaps
//             banks at end of frame and paints one trace per channel plus a
//             centre axis. Fixed 2-cycle render latency.
//  Options  : GEN_SCOPE_GRID_EN - adds a 64-pixel grid (0x202020) beneath
//             the axis, drawn regardless of capture state.
//  Revision : 1.0  initial release
// ============================================================================
module gen_scope_video #(
  parameter int VIDEO_X_BITWIDTH = 12,
  parameter int VIDEO_Y_BITWIDTH = 11,
  parameter int CHANNELS         = 2,
  parameter int SAMPLE_W         = 16,
  parameter int DEPTH_LOG2       = 9
) (
  input  wire logic                        I_clk_pixel,
  input  wire logic                        I_reset_n,
  input  wire logic [VIDEO_X_BITWIDTH-1:0] pixX,
  input  wire logic [VIDEO_Y_BITWIDTH-1:0] pixY,
  input  wire logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
  input  wire logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
  gen_scope_video_if.slave                 smp,
  output logic                             captured,
  output logic [23:0]                      rgb
);

  localparam int DW   = CHANNELS * SAMPLE_W;
  localparam int NCOL = 1 << DEPTH_LOG2;
  localparam int TO_W = DEPTH_LOG2 + 3;
  localparam int RW   = VIDEO_Y_BITWIDTH + 1;
  // Auto-trigger fires on the (4 * window)th strobe seen while armed.
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'((4 << DEPTH_LOG2) - 1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  disp_valid_q, disp_valid_d;
  logic                  captured_q, captured_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [SAMPLE_W-1:0]   prev_ch0_q, prev_ch0_d;
  logic [TO_W-1:0]       timeout_q, timeout_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [SAMPLE_W-1:0]   cur_ch0;
  logic                  end_of_frame;

  assign cur_ch0      = smp.sample[SAMPLE_W-1:0];
  assign end_of_frame = (pixX == screenWidth - VIDEO_X_BITWIDTH'(1)) &&
                        (pixY == screenHeight - VIDEO_Y_BITWIDTH'(1));

  // Capture FSM: trigger detection, window writes and end-of-frame swap.
  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    disp_valid_d = disp_valid_q;
    captured_d   = 1'b0;
    prev_valid_d = prev_valid_q;
    prev_ch0_d   = prev_ch0_q;
    timeout_d    = timeout_q;
    addr_d       = addr_q;
    wr_en        = 1'b0;
    wr_addr      = addr_q;
    case (state_q)
      ST_ARMED: begin
        if (smp.sample_valid) begin
          prev_ch0_d   = cur_ch0;
          prev_valid_d = 1'b1;
          // Rising crossing needs a previous sample; first strobe after arming only seeds it.
          if ((prev_valid_q &&
               ($signed(prev_ch0_q) < $signed(smp.trig_level)) &&
               ($signed(cur_ch0) >= $signed(smp.trig_level))) ||
              (timeout_q == TO_LAST)) begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            addr_d    = DEPTH_LOG2'(1);
            timeout_d = '0;
            state_d   = ST_CAPTURE;
          end else begin
            timeout_d = timeout_q + TO_W'(1);
          end
        end
      end
      ST_CAPTURE: begin
        if (smp.sample_valid) begin
          wr_en   = 1'b1;
          wr_addr = addr_q;
          addr_d  = addr_q + DEPTH_LOG2'(1);
          if (addr_q == ADDR_LAST) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        // Samples are ignored here, including one coincident with the swap.
        if (end_of_frame) begin
          wr_bank_d    = ~wr_bank_q;
          disp_valid_d = 1'b1;
          captured_d   = 1'b1;
          timeout_d    = '0;
          prev_valid_d = 1'b0;
          state_d      = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // Capture state registers.
  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      state_q      <= ST_ARMED;
      wr_bank_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      captured_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_ch0_q   <= '0;
      timeout_q    <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      disp_valid_q <= disp_valid_d;
      captured_q   <= captured_d;
      prev_valid_q <= prev_valid_d;
      prev_ch0_q   <= prev_ch0_d;
      timeout_q    <= timeout_d;
      addr_q       <= addr_d;
    end
  end

  // Double-buffered sample RAM: write into wr_bank, read the other bank.
  logic [DW-1:0] mem_q [0:2*NCOL-1];
  logic [DW-1:0] rd_data_q;

  // Single write port, synchronous read port (block-RAM friendly).
  always_ff @(posedge I_clk_pixel) begin
    if (I_reset_n && wr_en) begin
      mem_q[{wr_bank_q, wr_addr}] <= smp.sample;
    end
    rd_data_q <= mem_q[{~wr_bank_q, pixX[DEPTH_LOG2-1:0]}];
  end

  // Render stage 1: pipeline pixel row and column qualifiers alongside the read.
  logic [VIDEO_Y_BITWIDTH-1:0] pixy_s1_q, pixy_s1_d;
  logic                        inrange_s1_q, inrange_s1_d;
  logic                        disp_s1_q, disp_s1_d;
`ifdef GEN_SCOPE_GRID_EN
  logic [5:0]                  gridx_s1_q, gridx_s1_d;
`endif

  // Stage-1 next values.
  always_comb begin
    pixy_s1_d    = pixY;
    inrange_s1_d = ((pixX >> DEPTH_LOG2) == '0) && (pixX < screenWidth);
    disp_s1_d    = disp_valid_q;
`ifdef GEN_SCOPE_GRID_EN
    gridx_s1_d   = pixX[5:0];
`endif
  end

  // Stage-1 registers.
  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      pixy_s1_q    <= '0;
      inrange_s1_q <= 1'b0;
      disp_s1_q    <= 1'b0;
`ifdef GEN_SCOPE_GRID_EN
      gridx_s1_q   <= '0;
`endif
    end else begin
      pixy_s1_q    <= pixy_s1_d;
      inrange_s1_q <= inrange_s1_d;
      disp_s1_q    <= disp_s1_d;
`ifdef GEN_SCOPE_GRID_EN
      gridx_s1_q   <= gridx_s1_d;
`endif
    end
  end

  // Render stage 2: per-channel trace row from the top 8 sample bits.
  logic [VIDEO_Y_BITWIDTH-1:0] half_h;
  logic [CHANNELS-1:0]         hit;
  logic [CHANNELS-1:0]         unused_lsb;

  assign half_h = screenHeight >> 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]           top8;
    logic signed [RW-1:0] row;
    assign top8          = rd_data_q[c*SAMPLE_W + SAMPLE_W-1 -: 8];
    assign row           = $signed({1'b0, half_h}) - $signed({{(RW-8){top8[7]}}, top8});
    assign hit[c]        = !row[RW-1] && (row[RW-2:0] < screenHeight) &&
                           (pixy_s1_q == row[RW-2:0]);
    assign unused_lsb[c] = ^rd_data_q[c*SAMPLE_W +: SAMPLE_W-8];
  end

  function automatic logic [23:0] ch_colour(input int c);
    case (c)
      0:       ch_colour = 24'h00FF00;
      1:       ch_colour = 24'hFFFF00;
      2:       ch_colour = 24'h00FFFF;
      default: ch_colour = 24'hFF00FF;
    endcase
  endfunction

  logic [23:0] rgb_q, rgb_d;

  // Colour select: background, grid, axis, then traces with ch0 on top.
  always_comb begin
    rgb_d = 24'h000000;
`ifdef GEN_SCOPE_GRID_EN
    if ((gridx_s1_q == 6'd0) || (pixy_s1_q[5:0] == 6'd0)) begin
      rgb_d = 24'h202020;
    end
`endif
    if (pixy_s1_q == half_h) begin
      rgb_d = 24'h404040;
    end
    if (disp_s1_q && inrange_s1_q) begin
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (hit[c]) begin
          rgb_d = ch_colour(c);
        end
      end
    end
  end

  // Output colour register.
  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb      = rgb_q;
  assign captured = captured_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_scope_video.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gen_scope_video
//  Purpose  : Directed bench for gen_scope_video on a 1280x720 screen;
//             pixel coordinates are driven directly rather than scanned.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gen_scope_video;
  localparam int VX = 12;
  localparam int VY = 11;
  localparam int CH = 2;
  localparam int SW = 16;
  localparam int D  = 9;

  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] YELLOW = 24'hFFFF00;
  localparam logic [23:0] AXIS   = 24'h404040;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VX-1:0] pix_x;
  logic [VY-1:0] pix_y;
  logic [VX-1:0] scr_w;
  logic [VY-1:0] scr_h;
  logic          captured;
  logic [23:0]   rgb;

  int checks = 0;
  int errors = 0;

  gen_scope_video_if #(.CHANNELS(CH), .SAMPLE_W(SW)) sif ();

  gen_scope_video #(
    .VIDEO_X_BITWIDTH(VX), .VIDEO_Y_BITWIDTH(VY),
    .CHANNELS(CH), .SAMPLE_W(SW), .DEPTH_LOG2(D)
  ) dut (
    .I_clk_pixel (clk),
    .I_reset_n   (rst_n),
    .pixX        (pix_x),
    .pixY        (pix_y),
    .screenWidth (scr_w),
    .screenHeight(scr_h),
    .smp         (sif),
    .captured    (captured),
    .rgb         (rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] bg(input int x, input int y);
`ifdef GEN_SCOPE_GRID_EN
    return ((x % 64) == 0 || (y % 64) == 0) ? 24'h202020 : 24'h000000;
`else
    return 24'h000000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic [23:0] exp, input string tag);
    pix_x = VX'(x);
    pix_y = VY'(y);
    tick();
    tick();
    check(tag, rgb, exp);
  endtask

  task automatic strobe(input logic [15:0] c0, input logic [15:0] c1);
    sif.sample_valid = 1'b1;
    sif.sample       = {c1, c0};
    tick();
    sif.sample_valid = 1'b0;
  endtask

  task automatic frame_end(input logic exp_cap, input string tag);
    pix_x = VX'(1279);
    pix_y = VY'(719);
    tick();
    check(tag, {23'd0, captured}, {23'd0, exp_cap});
    pix_x = '0;
    pix_y = '0;
    tick();
    check({tag, "_pulse_end"}, {23'd0, captured}, 24'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    scr_w            = VX'(1280);
    scr_h            = VY'(720);
    pix_x            = '0;
    pix_y            = VY'(360);
    sif.sample_valid = 1'b0;
    sif.sample       = '0;
    sif.trig_level   = '0;

    // Reset state
    repeat (4) tick();
    check("reset_rgb", rgb, 24'h0);
    check("reset_captured", {23'd0, captured}, 24'd0);
    rst_n = 1'b1;

    // No capture yet: axis and background only
    pix(0, 360, AXIS, "axis_no_capture");
    pix(0, 296, bg(0, 296), "black_no_capture");
    pix(64, 100, bg(64, 100), "grid_64_100");
    pix(65, 100, 24'h000000, "grid_65_100");
    pix(64, 360, AXIS, "grid_axis_64_360");

    // Ramp on ch0 crosses 0; trigger on the sample equal to 0
    pix_x = '0;
    pix_y = '0;
    sif.trig_level = 16'h0000;
    for (int i = -1000; i <= 1000; i++) strobe(16'(i), 16'h4000);
    check("ramp_no_early_capture", {23'd0, captured}, 24'd0);
    frame_end(1'b1, "ramp_captured");
    pix(0, 360, GREEN, "ramp_col0");
    pix(300, 359, GREEN, "ramp_col300");
    pix(511, 359, GREEN, "ramp_col511");
    pix(300, 360, AXIS, "ramp_axis");
    pix(0, 296, YELLOW, "ramp_ch1");
    pix(600, 296, bg(600, 296), "ramp_out_of_range");
    pix(600, 360, AXIS, "ramp_oor_axis");

    // Reset in the middle of a capture window
    pix_x = '0;
    pix_y = '0;
    strobe(16'hFFFB, 16'h0000);
    strobe(16'h4000, 16'h0000);
    repeat (10) strobe(16'h4000, 16'h0000);
    pix_y = VY'(360);
    rst_n = 1'b0;
    repeat (4) tick();
    check("midcap_reset_rgb", rgb, 24'h0);
    rst_n = 1'b1;
    pix(0, 360, AXIS, "old_buffer_hidden");
    pix(0, 296, bg(0, 296), "old_ch1_hidden");
    check("midcap_no_captured", {23'd0, captured}, 24'd0);

    // Constant ch0 = 0x4000, ch1 = 0xC000
    pix_x = '0;
    pix_y = '0;
    strobe(16'hFFFF, 16'hC000);
    repeat (512) strobe(16'h4000, 16'hC000);
    frame_end(1'b1, "const_captured");
    pix(0, 296, GREEN, "const_ch0_col0");
    pix(511, 296, GREEN, "const_ch0_col511");
    pix(0, 424, YELLOW, "const_ch1_col0");
    pix(511, 424, YELLOW, "const_ch1_col511");
    pix(512, 296, bg(512, 296), "const_col512_black");
    pix(512, 360, AXIS, "const_col512_axis");
    pix(100, 360, AXIS, "const_axis");

    // Auto-trigger on the 2048th untriggered strobe
    pix_x = '0;
    pix_y = '0;
    sif.trig_level = 16'h1000;
    repeat (2558) strobe(16'h2000, 16'hE000);
    frame_end(1'b0, "auto_not_yet");
    strobe(16'h2000, 16'hE000);
    frame_end(1'b1, "auto_captured");
    pix(10, 328, GREEN, "auto_ch0");
    pix(10, 392, YELLOW, "auto_ch1");
    pix(10, 296, bg(10, 296), "auto_old_gone");

    // Strobes while FULL, including one on the swap cycle, are dropped
    pix_x = '0;
    pix_y = '0;
    sif.trig_level = 16'h0000;
    strobe(16'hFFFB, 16'h3000);
    repeat (512) strobe(16'h3000, 16'h3000);
    repeat (300) strobe(16'h7000, 16'h7000);
    sif.sample_valid = 1'b1;
    sif.sample       = {16'h7000, 16'h7000};
    pix_x = VX'(1279);
    pix_y = VY'(719);
    tick();
    check("full_swap_captured", {23'd0, captured}, 24'd1);
    sif.sample_valid = 1'b0;
    pix_x = '0;
    pix_y = '0;
    tick();
    for (int i = 0; i < 299; i++) strobe((i % 2) ? 16'h7000 : 16'hFFFB, 16'h7000);
    pix(0, 312, GREEN, "full_ch0_priority");
    pix(511, 312, GREEN, "full_col511");
    pix(0, 248, bg(0, 248), "full_dropped");
    check("full_no_extra_capture", {23'd0, captured}, 24'd0);

    // Latency exactly 2 at column 5
    pix(5, 0, bg(5, 0), "lat_prefill");
    pix_y = VY'(312);
    tick();
    check("lat_not_1", rgb, bg(5, 0));
    pix_y = '0;
    tick();
    check("lat_2", rgb, GREEN);
    tick();
    check("lat_back", rgb, bg(5, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
